// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing constants and types for the video sync generator
// Purpose : default raster timing (4 MHz board clock), counter widths and the
//           registered sync-output bundle shared by video_timebase and
//           video_sync_generator.
package video_timing_pkg;

    // Default raster timing in 4 MHz clocks / lines.
    localparam int unsigned DEF_LINE_CLKS   = 254;
    localparam int unsigned DEF_HSYNC_CLKS  = 19;
    localparam int unsigned DEF_BURST_START = 22;
    localparam int unsigned DEF_BURST_CLKS  = 10;
    localparam int unsigned DEF_FIELD_LINES = 262;
    localparam int unsigned DEF_VS_START    = 3;
    localparam int unsigned DEF_VS_LINES    = 3;

    // Counter widths; HALF_W holds a half-line index (2*line + 1).
    localparam int unsigned COL_W  = 9;
    localparam int unsigned LINE_W = 10;
    localparam int unsigned HALF_W = LINE_W + 1;

    // Registered sync outputs, all active-low except frame_start.
    typedef struct packed {
        logic csync_n;
        logic vsync_n;
        logic burst_n;
        logic frame_start;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{csync_n: 1'b1, vsync_n: 1'b1, burst_n: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/video_timebase.sv
// rtl/video_timebase.sv - column/line/field counters for the video sync generator
// Purpose : free-running raster counters; cleared synchronously while en_i is low.
// Config  : INTERLACE_EN defined -> field 0 is FIELD_LINES+1 lines, field 1 is FIELD_LINES.
// Ports   : clk_i   in  clock
//           rst_ni  in  asynchronous reset, active low
//           en_i    in  run enable; low clears all counters on the next edge
//           col_o   out current column, 0..LINE_CLKS-1
//           line_o  out current line within the field
//           field_o out current field id
module video_timebase
    import video_timing_pkg::*;
#(
    parameter int unsigned LINE_CLKS   = DEF_LINE_CLKS,
    parameter int unsigned FIELD_LINES = DEF_FIELD_LINES
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic [COL_W-1:0]  col_o,
    output logic [LINE_W-1:0] line_o,
    output logic              field_o
);

    localparam logic [COL_W-1:0]  COL_LAST        = COL_W'(LINE_CLKS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST_SHORT = LINE_W'(FIELD_LINES - 1);

    logic [COL_W-1:0]  col_q,   col_d;
    logic [LINE_W-1:0] line_q,  line_d;
    logic              field_q, field_d;
    logic [LINE_W-1:0] line_last;

`ifdef INTERLACE_EN
    localparam logic [LINE_W-1:0] LINE_LAST_LONG = LINE_W'(FIELD_LINES);
    // Field 0 carries the extra line so the two fields interleave by a half-line.
    assign line_last = field_q ? LINE_LAST_SHORT : LINE_LAST_LONG;
`else
    assign line_last = LINE_LAST_SHORT;
`endif

    always_comb begin
        col_d   = col_q;
        line_d  = line_q;
        field_d = field_q;
        if (!en_i) begin
            col_d   = '0;
            line_d  = '0;
            field_d = 1'b0;
        end else if (col_q == COL_LAST) begin
            col_d = '0;
            if (line_q == line_last) begin
                line_d  = '0;
                field_d = ~field_q;
            end else begin
                line_d = line_q + 1'b1;
            end
        end else begin
            col_d = col_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q   <= '0;
            line_q  <= '0;
            field_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            line_q  <= line_d;
            field_q <= field_d;
        end
    end

    assign col_o   = col_q;
    assign line_o  = line_q;
    assign field_o = field_q;

endmodule

// File: rtl/video_sync_generator.sv
// rtl/video_sync_generator.sv - LM1881-style separated sync generator (stand-alone timing source)
// Purpose : produces csync_n/vsync_n/burst_n/field plus raster position from the 4 MHz clock.
// Config  : INTERLACE_EN defined -> 263/262-line fields, field 1 vertical sync delayed one half-line.
// Ports   : clk         in  4 MHz clock
//           reset_n     in  asynchronous reset, active low
//           en          in  run enable; low = hold idle
//           csync_n     out composite sync, active low (registered)
//           vsync_n     out vertical sync, active low (registered)
//           burst_n     out burst/back-porch gate, active low (registered)
//           field       out field id, 0 = first field
//           frame_start out one-clock pulse with the outputs of field 0, line 0, col 0
//           col_cnt     out current column
//           line_cnt    out current line within the field
module video_sync_generator
    import video_timing_pkg::*;
#(
    parameter int unsigned LINE_CLKS   = DEF_LINE_CLKS,
    parameter int unsigned HSYNC_CLKS  = DEF_HSYNC_CLKS,
    parameter int unsigned BURST_START = DEF_BURST_START,
    parameter int unsigned BURST_CLKS  = DEF_BURST_CLKS,
    parameter int unsigned FIELD_LINES = DEF_FIELD_LINES,
    parameter int unsigned VS_START    = DEF_VS_START,
    parameter int unsigned VS_LINES    = DEF_VS_LINES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    output logic              csync_n,
    output logic              vsync_n,
    output logic              burst_n,
    output logic              field,
    output logic              frame_start,
    output logic [COL_W-1:0]  col_cnt,
    output logic [LINE_W-1:0] line_cnt
);

    localparam logic [COL_W-1:0]  HALF_C   = COL_W'(LINE_CLKS / 2);
    localparam logic [COL_W-1:0]  HSYNC_C  = COL_W'(HSYNC_CLKS);
    localparam logic [COL_W-1:0]  BROAD_C  = COL_W'(LINE_CLKS / 2 - HSYNC_CLKS);
    localparam logic [COL_W-1:0]  BURST_LO = COL_W'(BURST_START);
    localparam logic [COL_W-1:0]  BURST_HI = COL_W'(BURST_START + BURST_CLKS);
    localparam logic [HALF_W-1:0] VS_LO    = HALF_W'(2 * VS_START);
    localparam logic [HALF_W-1:0] VS_HI    = HALF_W'(2 * (VS_START + VS_LINES));

    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic              fld;

    video_timebase #(
        .LINE_CLKS   (LINE_CLKS),
        .FIELD_LINES (FIELD_LINES)
    ) u_timebase (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .en_i    (en),
        .col_o   (col),
        .line_o  (line),
        .field_o (fld)
    );

    // Half-line position: index 2*line + (second half), and column within the half.
    logic              second_half;
    logic [COL_W-1:0]  h_pos;
    logic [HALF_W-1:0] half_idx;

    assign second_half = (col >= HALF_C);
    assign h_pos       = second_half ? (col - HALF_C) : col;
    assign half_idx    = {line, second_half};

    // Field 1 of an interlaced frame starts its vertical interval one half-line later.
    logic              vs_off;
    logic [HALF_W-1:0] vs_lo;
    logic [HALF_W-1:0] vs_hi;

`ifdef INTERLACE_EN
    assign vs_off = fld;
`else
    assign vs_off = 1'b0;
`endif

    assign vs_lo = VS_LO + {{(HALF_W-1){1'b0}}, vs_off};
    assign vs_hi = VS_HI + {{(HALF_W-1){1'b0}}, vs_off};

    logic in_vs;
    logic line_in_vs;

    assign in_vs = (half_idx >= vs_lo) && (half_idx < vs_hi);
    // Burst is suppressed for the whole line if either of its halves is in the interval.
    assign line_in_vs = ({line, 1'b1} >= vs_lo) && ({line, 1'b0} < vs_hi);

    sync_t sync_q, sync_d;

    always_comb begin
        sync_d = SYNC_IDLE;
        if (en) begin
            // Broad pulses during the vertical interval, normal hsync elsewhere.
            sync_d.csync_n     = in_vs ? (h_pos >= BROAD_C) : (col >= HSYNC_C);
            sync_d.vsync_n     = ~in_vs;
            sync_d.burst_n     = line_in_vs | ~((col >= BURST_LO) && (col < BURST_HI));
            sync_d.frame_start = ~fld && (line == '0) && (col == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= SYNC_IDLE;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign csync_n     = sync_q.csync_n;
    assign vsync_n     = sync_q.vsync_n;
    assign burst_n     = sync_q.burst_n;
    assign frame_start = sync_q.frame_start;
    assign field       = fld;
    assign col_cnt     = col;
    assign line_cnt    = line;

endmodule

// File: tb/tb_video_sync_generator.sv
// tb/tb_video_sync_generator.sv - self-checking bench for video_sync_generator
module tb_video_sync_generator;

    localparam int LC   = 254;
    localparam int HS   = 19;
    localparam int BS   = 22;
    localparam int BC   = 10;
    localparam int FL   = 262;
    localparam int VSS  = 3;
    localparam int VSL  = 3;
    localparam int HALF = LC / 2;
`ifdef INTERLACE_EN
    localparam int L0 = FL + 1;
    localparam int L1 = FL;
    localparam bit ILACE = 1'b1;
`else
    localparam int L0 = FL;
    localparam int L1 = FL;
    localparam bit ILACE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0;
    logic       csync_n, vsync_n, burst_n, field, frame_start;
    logic [8:0] col_cnt;
    logic [9:0] line_cnt;

    video_sync_generator dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .csync_n     (csync_n),
        .vsync_n     (vsync_n),
        .burst_n     (burst_n),
        .field       (field),
        .frame_start (frame_start),
        .col_cnt     (col_cnt),
        .line_cnt    (line_cnt)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   t;                       // active clocks since enable = raster position
    logic e_cs, e_vs, e_bu, e_fs;  // expected registered outputs

    function automatic void pos_of(input int tt, output int c, output int l, output int f);
        int p;
        p = tt % ((L0 + L1) * LC);
        f = (p >= L0 * LC) ? 1 : 0;
        if (f == 1) p = p - L0 * LC;
        l = p / LC;
        c = p % LC;
    endfunction

    function automatic logic [3:0] sync_of(input int c, input int l, input int f);
        int hl, lo, hi;
        bit in_vs, touch;
        logic cs, vs, bu, fs;
        hl    = 2 * l + ((c >= HALF) ? 1 : 0);
        lo    = 2 * VSS + ((ILACE && f == 1) ? 1 : 0);
        hi    = 2 * (VSS + VSL) + ((ILACE && f == 1) ? 1 : 0);
        in_vs = (hl >= lo) && (hl < hi);
        touch = (2 * l + 1 >= lo) && (2 * l < hi);
        cs    = in_vs ? !((c % HALF) < HALF - HS) : !(c < HS);
        vs    = !in_vs;
        bu    = touch ? 1'b1 : !(c >= BS && c < BS + BC);
        fs    = (f == 0 && l == 0 && c == 0);
        return {cs, vs, bu, fs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic reset_model();
        t    = 0;
        e_cs = 1'b1;
        e_vs = 1'b1;
        e_bu = 1'b1;
        e_fs = 1'b0;
    endtask

    task automatic cmp_now();
        int c, l, f;
        pos_of(t, c, l, f);
        chk("col_cnt",     {23'd0, col_cnt},  c);
        chk("line_cnt",    {22'd0, line_cnt}, l);
        chk("field",       {31'd0, field},    f);
        chk("csync_n",     {31'd0, csync_n},  {31'd0, e_cs});
        chk("vsync_n",     {31'd0, vsync_n},  {31'd0, e_vs});
        chk("burst_n",     {31'd0, burst_n},  {31'd0, e_bu});
        chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    endtask

    // One clock: model the edge from the en level held across it, then compare.
    task automatic step();
        int c, l, f;
        if (en && reset_n) begin
            pos_of(t, c, l, f);
            {e_cs, e_vs, e_bu, e_fs} = sync_of(c, l, f);
            t++;
        end else begin
            reset_model();
        end
        @(posedge clk);
        #1;
        cmp_now();
    endtask

    int first_cs, cs_l0, vs_cnt, cs_vs, bu_cnt, first_bu, flip, fs_cnt;

    initial begin
        reset_model();
        #1 reset_n = 1'b0;
        #1 cmp_now();
        repeat (3) step();
        reset_n = 1'b1;
        repeat (1000) step();

        // Long run from enable through the first field wrap.
        first_cs = 0; cs_l0 = 0; vs_cnt = 0; cs_vs = 0;
        bu_cnt = 0; first_bu = 0; flip = 0; fs_cnt = 0;
        en = 1'b1;
        for (int k = 1; k <= L0 * LC + 300; k++) begin
            step();
            if (k <= LC && !csync_n) begin
                cs_l0++;
                if (first_cs == 0) first_cs = k;
            end
            if (k == LC + 1) chk("csync_period", {31'd0, csync_n}, 0);
            if (k <= L0 * LC) begin
                if (!vsync_n) vs_cnt++;
                if (!vsync_n && !csync_n) cs_vs++;
                if (!burst_n) begin
                    bu_cnt++;
                    if (first_bu == 0) first_bu = k;
                end
            end
            if (field && flip == 0) flip = k;
            if (frame_start) fs_cnt++;
        end
        chk("first_csync_step", first_cs, 1);
        chk("csync_low_line0",  cs_l0, HS);
        chk("vsync_low_clks",   vs_cnt, VSL * LC);
        chk("broad_low_clks",   cs_vs, 2 * VSL * (HALF - HS));
        chk("first_burst_step", first_bu, BS + 1);
        chk("burst_low_clks",   bu_cnt, (L0 - VSL) * BC);
        chk("field_flip_step",  flip, L0 * LC);
        chk("frame_start_cnt",  fs_cnt, 1);

        // Drop enable in the middle of vertical sync, then restart.
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (4 * LC + 40) step();
        chk("mid_vs_vsync", {31'd0, vsync_n}, 0);
        en = 1'b0;
        step();
        chk("drop_vsync",  {31'd0, vsync_n}, 1);
        chk("drop_csync",  {31'd0, csync_n}, 1);
        chk("drop_col",    {23'd0, col_cnt}, 0);
        chk("drop_line",   {22'd0, line_cnt}, 0);
        en = 1'b1;
        step();
        chk("restart_field", {31'd0, field}, 0);
        chk("restart_fs",    {31'd0, frame_start}, 1);

        // Random enable/disable segments.
        for (int s = 0; s < 4; s++) begin
            en = 1'b1;
            repeat ($urandom_range(50, 1500)) step();
            en = 1'b0;
            repeat ($urandom_range(1, 8)) step();
        end

        // Asynchronous reset in the middle of a line while hsync is low.
        en = 1'b1;
        repeat (10) step();
        chk("pre_reset_csync", {31'd0, csync_n}, 0);
        #2 reset_n = 1'b0;
        reset_model();
        #1;
        cmp_now();
        en = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
